// File: rtl/flash_bus_pkg.sv
// Shared state encoding, flow codes and phase-counter sizing for the flash-bus responder.
package flash_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } fb_state_t;

  localparam logic FL_FLOW_READ  = 1'b0;
  localparam logic FL_FLOW_WRITE = 1'b1;

  // Width that holds the longest phase length minus one (the value loaded on entry).
  function automatic int phase_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/flash_phase_timer.sv
// Loadable down-counter that stops at zero; zero flag marks the last cycle of a phase.
// Latency: load takes effect at the next edge; no backpressure.
module flash_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             CLK_50MHZ,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             cnt_zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/flash_bus_responder.sv
// Runs one timed parallel-flash read/write per accepted fb_start and pulses fb_done at the end.
// Latency: SETUP+PULSE+HOLD+1 cycles; fb_start while busy is dropped, not queued.
module flash_bus_responder
  import flash_bus_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 5,
  parameter int HOLD_CYC  = 1
) (
  input  logic              CLK_50MHZ,
  input  logic              RST_N,
  input  logic              fb_start,
  input  logic              FL_FLOW,
  input  logic [ADDR_W-1:0] FL_ADDR,
  input  logic [DATA_W-1:0] FL_DATA,
  output logic              fb_done,
  output logic              fb_busy,
  output logic [DATA_W-1:0] fb_rdata,
  output logic [ADDR_W-1:0] FLASH_A,
  inout  wire  [DATA_W-1:0] FLASH_DQ,
  output logic              FLASH_CE_N,
  output logic              FLASH_OE_N,
  output logic              FLASH_WE_N
);

  localparam int CNT_W = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  fb_state_t         state_q, state_d;
  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              accept;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;
  logic              sample_rd;
  logic              in_cycle_d;
  logic              dq_oe_q;
  logic [DATA_W-1:0] dq_out_q;

  flash_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK_50MHZ (CLK_50MHZ),
    .RST_N     (RST_N),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .cnt_zero  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    sample_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fb_start) begin
          accept   = 1'b1;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d   = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
          sample_rd = (req_wr_q == FL_FLOW_READ);
        end
      end
      ST_HOLD: begin
        if (tmr_zero) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins are decoded from the next state so every flash output leaves a flop.
  assign req_wr_d   = accept ? (FL_FLOW == FL_FLOW_WRITE) : req_wr_q;
  assign req_addr_d = accept ? FL_ADDR : req_addr_q;
  assign req_data_d = accept ? FL_DATA : req_data_q;
  assign in_cycle_d = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      fb_done    <= 1'b0;
      fb_busy    <= 1'b0;
      fb_rdata   <= '0;
      FLASH_A    <= '0;
      FLASH_CE_N <= 1'b1;
      FLASH_OE_N <= 1'b1;
      FLASH_WE_N <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      fb_done    <= (state_d == ST_DONE);
      fb_busy    <= (state_d != ST_IDLE);
      if (sample_rd) fb_rdata <= FLASH_DQ;
      if (in_cycle_d) FLASH_A <= req_addr_d;
      FLASH_CE_N <= !in_cycle_d;
      FLASH_OE_N <= !((state_d == ST_PULSE) && !req_wr_d);
      FLASH_WE_N <= !((state_d == ST_PULSE) && req_wr_d);
      dq_oe_q    <= in_cycle_d && req_wr_d;
      dq_out_q   <= req_data_d;
    end
  end

  assign FLASH_DQ = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_flash_bus_responder.sv
// Bench for flash_bus_responder: default-timing instance driven from a vector table with a
// read-data scoreboard, plus a 1/1/1-timing instance for back-to-back throughput.
module tb_flash_bus_responder;

  localparam int S    = 2;
  localparam int P    = 5;
  localparam int H    = 1;
  localparam int LAST = S + P + H;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n;
  logic       fb_start, fl_flow;
  logic [7:0] fl_addr, fl_data, fval;
  logic       fb_done, fb_busy, ce_n, oe_n, we_n;
  logic [7:0] fb_rdata, flash_a;
  tri1  [7:0] flash_dq;
  assign flash_dq = (!oe_n) ? fval : 8'bz;

  logic       f_start;
  logic [7:0] f_addr, f_data, f_fval;
  logic       f_done, f_busy, f_ce_n, f_oe_n, f_we_n;
  logic [7:0] f_rdata, f_a;
  tri1  [7:0] f_dq;
  assign f_dq = (!f_oe_n) ? f_fval : 8'bz;

  flash_bus_responder dut (
    .CLK_50MHZ(clk), .RST_N(rst_n), .fb_start(fb_start), .FL_FLOW(fl_flow),
    .FL_ADDR(fl_addr), .FL_DATA(fl_data), .fb_done(fb_done), .fb_busy(fb_busy),
    .fb_rdata(fb_rdata), .FLASH_A(flash_a), .FLASH_DQ(flash_dq),
    .FLASH_CE_N(ce_n), .FLASH_OE_N(oe_n), .FLASH_WE_N(we_n)
  );

  flash_bus_responder #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_fast (
    .CLK_50MHZ(clk), .RST_N(rst_n), .fb_start(f_start), .FL_FLOW(1'b0),
    .FL_ADDR(f_addr), .FL_DATA(f_data), .fb_done(f_done), .fb_busy(f_busy),
    .fb_rdata(f_rdata), .FLASH_A(f_a), .FLASH_DQ(f_dq),
    .FLASH_CE_N(f_ce_n), .FLASH_OE_N(f_oe_n), .FLASH_WE_N(f_we_n)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  logic [7:0] sbq[$];
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each completion must match the oldest outstanding request.
  always @(negedge clk) begin
    if (fb_done) begin
      n_done++;
      check("sb_pending", 32'(sbq.size() != 0), 32'(1));
      if (sbq.size() != 0) check("sb_rdata", 32'(fb_rdata), 32'(sbq.pop_front()));
    end
  end

  typedef struct {
    logic       flow;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] fval;
    logic       scr;
    logic [11:0] ign;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input int vi, input vec_t v);
    int   d0;
    logic strobe;
    logic [7:0] dq_exp;
    fl_flow  = v.flow;
    fl_addr  = v.addr;
    fl_data  = v.wdata;
    fval     = v.fval;
    fb_start = 1'b1;
    if (v.flow) sbq.push_back(last_rd);
    else begin
      sbq.push_back(v.fval);
      last_rd = v.fval;
    end
    d0 = n_done;
    for (int k = 1; k <= LAST + 3; k++) begin
      tick();
      fb_start = v.ign[k];
      if (v.scr && k == 1) begin
        fl_addr = 8'hFF;
        fl_data = 8'hFF;
      end
      strobe = (k >= S + 1) && (k <= S + P);
      if (v.flow) dq_exp = (k <= LAST) ? v.wdata : 8'hFF;
      else        dq_exp = strobe ? v.fval : 8'hFF;
      check($sformatf("ce_n v%0d c%0d", vi, k), 32'(ce_n), 32'(!(k <= LAST)));
      check($sformatf("oe_n v%0d c%0d", vi, k), 32'(oe_n), 32'(!(strobe && !v.flow)));
      check($sformatf("we_n v%0d c%0d", vi, k), 32'(we_n), 32'(!(strobe && v.flow)));
      check($sformatf("busy v%0d c%0d", vi, k), 32'(fb_busy), 32'(k <= LAST + 1));
      check($sformatf("done v%0d c%0d", vi, k), 32'(fb_done), 32'(k == LAST + 1));
      check($sformatf("dq v%0d c%0d", vi, k), 32'(flash_dq), 32'(dq_exp));
      if (k <= LAST) check($sformatf("addr v%0d c%0d", vi, k), 32'(flash_a), 32'(v.addr));
    end
    check($sformatf("done_count v%0d", vi), 32'(n_done - d0), 32'(1));
  endtask

  initial begin
    int   d0;
    vec_t rv;
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 12'h000};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 12'h000};
    vecs[2] = '{1'b1, 8'hC7, 8'h3E, 8'h00, 1'b0, 12'h210};
    vecs[3] = '{1'b0, 8'h81, 8'h00, 8'hC3, 1'b1, 12'h000};
    vecs[4] = '{1'b1, 8'h55, 8'h69, 8'h00, 1'b1, 12'h000};
    vecs[5] = '{1'b0, 8'h7E, 8'h00, 8'h24, 1'b0, 12'h210};

    rst_n = 1'b0; fb_start = 1'b0; fl_flow = 1'b0; fl_addr = 8'h00; fl_data = 8'h00;
    fval = 8'h00; f_start = 1'b0; f_addr = 8'h20; f_data = 8'h00; f_fval = 8'h77;
    tick();
    tick();
    check("rst done", 32'(fb_done), 32'(0));
    check("rst busy", 32'(fb_busy), 32'(0));
    check("rst rdata", 32'(fb_rdata), 32'(0));
    check("rst addr", 32'(flash_a), 32'(0));
    check("rst ce_n", 32'(ce_n), 32'(1));
    check("rst oe_n", 32'(oe_n), 32'(1));
    check("rst we_n", 32'(we_n), 32'(1));
    check("rst dq", 32'(flash_dq), 32'(8'hFF));
    check("rst fast busy", 32'(f_busy), 32'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // Reset during the write strobe aborts the cycle without a completion.
    fl_flow = 1'b1; fl_addr = 8'h44; fl_data = 8'h96; fb_start = 1'b1;
    tick();
    fb_start = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    check("abort we_n before", 32'(we_n), 32'(0));
    d0 = n_done;
    rst_n = 1'b0;
    tick();
    check("abort we_n", 32'(we_n), 32'(1));
    check("abort ce_n", 32'(ce_n), 32'(1));
    check("abort dq", 32'(flash_dq), 32'(8'hFF));
    check("abort busy", 32'(fb_busy), 32'(0));
    check("abort done", 32'(fb_done), 32'(0));
    rst_n = 1'b1;
    sbq.delete();
    last_rd = 8'h00;
    for (int k = 0; k < 12; k++) tick();
    check("abort no done", 32'(n_done - d0), 32'(0));
    check("abort rdata cleared", 32'(fb_rdata), 32'(0));
    rv = '{1'b0, 8'h99, 8'h00, 8'hB4, 1'b0, 12'h000};
    run_txn(6, rv);

    // Minimum timing, fb_start held high: completions at 4, 9, 14.
    f_fval  = 8'h77;
    f_start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 5) f_fval = 8'h81;
      check($sformatf("fast done c%0d", k), 32'(f_done), 32'(k == 4 || k == 9 || k == 14));
      check($sformatf("fast busy c%0d", k), 32'(f_busy), 32'((k % 5) != 0));
      if (k == 4) check("fast rdata c4", 32'(f_rdata), 32'(8'h77));
      if (k == 9 || k == 14) check($sformatf("fast rdata c%0d", k), 32'(f_rdata), 32'(8'h81));
    end
    f_start = 1'b0;
    tick();
    tick();
    check("sb drained", 32'(sbq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
